// File: rtl/two_phase_clkgen.sv
// ---------------------------------------------------------------------------
// two_phase_clkgen
//   Non-overlapping two-phase clock generator for latch-based datapaths.
//   One period is P1 -> GAP1 -> P2 -> GAP2. Each phase is high for
//   HIGH_CYCLES master clocks, followed by GAP_CYCLES master clocks of dead
//   time. Periods are started by RUN (free run) or, when CLKGEN_STEP_EN is
//   defined, by a single-period STEP_REQ/STEP_ACK four-phase handshake.
//
// Configuration macro:
//   CLKGEN_STEP_EN  - defined: single-step handshake present.
//                     undefined: STEP_REQ ignored, STEP_ACK tied low.
//
// Parameters:
//   HIGH_CYCLES - CLK cycles each phase is high (values < 1 act as 1)
//   GAP_CYCLES  - CLK cycles of dead time after each phase (values < 1 act as 1)
//
// Ports:
//   CLK        in   master clock, rising edge
//   nRST       in   asynchronous active-low reset
//   RUN        in   free-run enable, sampled at period boundaries
//   STEP_REQ   in   single-period request
//   STEP_ACK   out  single-period acknowledge
//   PHI1/nPHI1 out  phase 1 and its registered complement
//   PHI2/nPHI2 out  phase 2 and its registered complement
//   BUSY       out  high whenever the FSM is not IDLE
//   CYCLE_CNT  out  completed periods, wraps at 16 bits
// ---------------------------------------------------------------------------
module two_phase_clkgen #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        RUN,
  input  logic        STEP_REQ,
  output logic        STEP_ACK,
  output logic        PHI1,
  output logic        nPHI1,
  output logic        PHI2,
  output logic        nPHI2,
  output logic        BUSY,
  output logic [15:0] CYCLE_CNT
);

  localparam int HC   = (HIGH_CYCLES < 1) ? 1 : HIGH_CYCLES;
  localparam int GC   = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam int TMAX = (HC > GC) ? HC : GC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  // The timer counts down to zero, so a state lasting N cycles loads N-1.
  localparam logic [TW-1:0] HIGH_LOAD = TW'(HC - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GC - 1);
  localparam logic [TW-1:0] TIMER_ONE = TW'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    GAP1 = 3'd2,
    P2   = 3'd3,
    GAP2 = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   cycle_cnt_q, cycle_cnt_d;
  logic          phi1_q, phi1_d, nphi1_q;
  logic          phi2_q, phi2_d, nphi2_q;
  logic          busy_q, busy_d;
  logic          ack_q, ack_d;
  logic          stepped_q, stepped_d;
  logic          step_go_s;
  logic          timer_done_s;

`ifdef CLKGEN_STEP_EN
  // RUN has priority; a step is only taken once the previous ack is cleared.
  assign step_go_s = ~RUN & STEP_REQ & ~ack_q;
`else
  logic unused_step_req_s;
  assign unused_step_req_s = STEP_REQ;
  assign step_go_s         = 1'b0;
`endif

  assign timer_done_s = (timer_q == {TW{1'b0}});

  // Next-state, timer, counter and handshake logic.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cycle_cnt_d = cycle_cnt_q;
    stepped_d   = stepped_q;
`ifdef CLKGEN_STEP_EN
    // Ack holds until STEP_REQ is sampled low, then drops on that edge.
    if (ack_q && !STEP_REQ) begin
      ack_d = 1'b0;
    end else begin
      ack_d = ack_q;
    end
`else
    ack_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (RUN) begin
          state_d   = P1;
          timer_d   = HIGH_LOAD;
          stepped_d = 1'b0;
        end else if (step_go_s) begin
          state_d   = P1;
          timer_d   = HIGH_LOAD;
          stepped_d = 1'b1;
        end else begin
          state_d = IDLE;
          timer_d = {TW{1'b0}};
        end
      end
      P1: begin
        if (timer_done_s) begin
          state_d = GAP1;
          timer_d = GAP_LOAD;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      GAP1: begin
        if (timer_done_s) begin
          state_d = P2;
          timer_d = HIGH_LOAD;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      P2: begin
        if (timer_done_s) begin
          state_d = GAP2;
          timer_d = GAP_LOAD;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      GAP2: begin
        if (timer_done_s) begin
          cycle_cnt_d = cycle_cnt_q + 16'd1;
`ifdef CLKGEN_STEP_EN
          if (stepped_q) begin
            ack_d = 1'b1;
          end else begin
            ack_d = ack_d;
          end
`endif
          stepped_d = 1'b0;
          // RUN only matters here, so a mid-period drop never truncates.
          if (RUN) begin
            state_d = P1;
            timer_d = HIGH_LOAD;
          end else begin
            state_d = IDLE;
            timer_d = {TW{1'b0}};
          end
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        timer_d   = {TW{1'b0}};
        stepped_d = 1'b0;
      end
    endcase

    // Outputs are decoded from the next state so the registers line up
    // with the state register and never see an input combinationally.
    phi1_d = (state_d == P1);
    phi2_d = (state_d == P2);
    busy_d = (state_d != IDLE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      timer_q     <= {TW{1'b0}};
      cycle_cnt_q <= 16'h0000;
      phi1_q      <= 1'b0;
      nphi1_q     <= 1'b1;
      phi2_q      <= 1'b0;
      nphi2_q     <= 1'b1;
      busy_q      <= 1'b0;
      ack_q       <= 1'b0;
      stepped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cycle_cnt_q <= cycle_cnt_d;
      phi1_q      <= phi1_d;
      nphi1_q     <= ~phi1_d;
      phi2_q      <= phi2_d;
      nphi2_q     <= ~phi2_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      stepped_q   <= stepped_d;
    end
  end

  assign PHI1      = phi1_q;
  assign nPHI1     = nphi1_q;
  assign PHI2      = phi2_q;
  assign nPHI2     = nphi2_q;
  assign BUSY      = busy_q;
  assign STEP_ACK  = ack_q;
  assign CYCLE_CNT = cycle_cnt_q;

endmodule

// File: doc/two_phase_clkgen.md
TWO_PHASE_CLKGEN -- requirements
Module: two_phase_clkgen

Interface
REQ-001 The block SHALL have a parameter HIGH_CYCLES, default 4, setting the CLK cycles each phase is high; values below 1 SHALL be treated as 1.
REQ-002 The block SHALL have a parameter GAP_CYCLES, default 1, setting the CLK cycles of dead time after each phase; values below 1 SHALL be treated as 1.
REQ-003 The block SHALL have the port CLK, input, 1 bit: single master clock, rising edge active.
REQ-004 The block SHALL have the port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have the port RUN, input, 1 bit: free-run enable, sampled at period boundaries.
REQ-006 The block SHALL have the port STEP_REQ, input, 1 bit: single-period request, four-phase handshake.
REQ-007 The block SHALL have the port STEP_ACK, output, 1 bit: single-period acknowledge.
REQ-008 The block SHALL have the ports PHI1 and nPHI1, outputs, 1 bit each: phase 1 and its complement, for D_LATCH CLK/nCLK.
REQ-009 The block SHALL have the ports PHI2 and nPHI2, outputs, 1 bit each: phase 2 and its complement.
REQ-010 The block SHALL have the port BUSY, output, 1 bit: high whenever the FSM is not IDLE.
REQ-011 The block SHALL have the port CYCLE_CNT, output, 16 bits: count of completed PHI1/PHI2 periods.

Function
REQ-012 The FSM SHALL have the states IDLE, P1, GAP1, P2 and GAP2.
REQ-013 P1 and P2 SHALL each last exactly HIGH_CYCLES CLK cycles; GAP1 and GAP2 SHALL each last exactly GAP_CYCLES CLK cycles, timed by a down-counter loaded on state entry.
REQ-014 PHI1 SHALL be high only in P1, PHI2 only in P2, and both SHALL be low in IDLE, GAP1 and GAP2.
REQ-015 All phase outputs SHALL be registered; nPHIx SHALL be the exact registered complement of PHIx, with no combinational path from any input.
REQ-016 PHI1 and PHI2 SHALL never be high in the same cycle, and each falling phase SHALL be followed by at least GAP_CYCLES cycles with both phases low.
REQ-017 In IDLE with RUN=1 sampled at edge k, the FSM SHALL enter P1 and drive PHI1 high from edge k+1.
REQ-018 At the end of GAP2, the FSM SHALL go to P1 if RUN=1 and to IDLE otherwise.
REQ-019 Deasserting RUN mid-period SHALL never truncate that period.
REQ-020 CYCLE_CNT SHALL increment by 1 on each exit from GAP2 and SHALL wrap from 0xFFFF to 0x0000.
REQ-021 A step SHALL be accepted in IDLE when RUN=0, STEP_REQ=1 and STEP_ACK=0; the FSM SHALL then run exactly one P1-GAP1-P2-GAP2 period.
REQ-022 STEP_ACK SHALL go high on the edge that exits GAP2 of a stepped period and SHALL stay high until STEP_REQ is sampled low, then clear on the next edge.
REQ-023 No new step SHALL be accepted while STEP_ACK=1.
REQ-024 When RUN=1 and STEP_REQ=1 in IDLE in the same cycle, RUN SHALL win; the step is not accepted and STEP_ACK stays 0.
REQ-025 If RUN rises during a stepped period, the FSM SHALL continue into free run at the period boundary, and STEP_ACK SHALL still complete per REQ-022.

Reset
REQ-026 nRST low SHALL force, immediately and asynchronously, mid-phase included: state IDLE, PHI1=PHI2=0, nPHI1=nPHI2=1, STEP_ACK=0, BUSY=0, CYCLE_CNT=0, timer=0.
REQ-027 After nRST rises, the first phase SHALL start no earlier than the edge after RUN or a step is sampled.

Configuration
REQ-028 With macro CLKGEN_STEP_EN defined, the step logic of REQ-021 to REQ-025 SHALL be present.
REQ-029 Without CLKGEN_STEP_EN, STEP_REQ SHALL be ignored, STEP_ACK SHALL be tied to 0, and only RUN SHALL start periods.

Verification
REQ-030 Defaults, RUN=1 held for 30 cycles: PHI1 high 4 cycles, both low 1, PHI2 high 4, both low 1 (period 10), CYCLE_CNT=3, and no overlap.
REQ-031 RUN dropped 2 cycles into P2: P2 completes its full 4 cycles plus GAP2, then the FSM enters IDLE and BUSY falls.
REQ-032 CLKGEN_STEP_EN defined, RUN=0, STEP_REQ held high: exactly one period runs, STEP_ACK rises at GAP2 exit and clears 1 cycle after STEP_REQ falls, and no second period starts.
REQ-033 RUN=1 and STEP_REQ=1 together in IDLE: free run starts and STEP_ACK stays 0.
REQ-034 CYCLE_CNT preloaded via 65535 periods, then one more period: CYCLE_CNT reads 0x0000.
REQ-035 nRST pulsed low during P1: PHI1 falls asynchronously, nPHI1=1, CYCLE_CNT=0, and a restart with HIGH_CYCLES=2, GAP_CYCLES=3 gives period 10.
